// File: rtl/atm_pkg.sv
// Shared encodings and defaults for the ATM host link.
// Also imported by the ATM front-end.
package atm_pkg;

  localparam logic [6:0] DEF_THRESHOLD    = 7'd90;
  localparam logic [6:0] DEF_INIT_BALANCE = 7'd110;
  localparam logic [1:0] DEF_INIT_PIN     = 2'b10;
  localparam int         DEF_MAX_TRIES    = 3;

  typedef enum logic [2:0] {
    OP_VERIFY   = 3'd0,
    OP_WITHDRAW = 3'd1,
    OP_DEPOSIT  = 3'd2,
    OP_BALANCE  = 3'd3,
    OP_CLOSE    = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_BAD_PIN  = 3'd1,
    ST_LOCKED   = 3'd2,
    ST_INSUFF   = 3'd3,
    ST_OVERFLOW = 3'd4,
    ST_NO_SESS  = 3'd5,
    ST_ILLEGAL  = 3'd6
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/atm_acct_table.sv
// Per-account balance, bad-PIN count and lock bit.
// One combinational read port, one synchronous write port.
module atm_acct_table
  import atm_pkg::*;
#(
  parameter int NUM_ACCTS = 4,
  parameter int ACCT_W = 2,
  parameter int AMT_W = 7,
  parameter int FAIL_W = 2,
  parameter logic [AMT_W-1:0] INIT_BALANCE = AMT_W'(DEF_INIT_BALANCE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ACCT_W-1:0] rd_acct,
  output logic [AMT_W-1:0]  rd_bal,
  output logic [FAIL_W-1:0] rd_fails,
  output logic              rd_lock,
  input  logic              wr_en,
  input  logic [ACCT_W-1:0] wr_acct,
  input  logic [AMT_W-1:0]  wr_bal,
  input  logic [FAIL_W-1:0] wr_fails,
  input  logic              wr_lock
);

  logic [AMT_W-1:0]  bal_q   [NUM_ACCTS];
  logic [AMT_W-1:0]  bal_d   [NUM_ACCTS];
  logic [FAIL_W-1:0] fails_q [NUM_ACCTS];
  logic [FAIL_W-1:0] fails_d [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock_q, lock_d;

  assign rd_bal   = bal_q[rd_acct];
  assign rd_fails = fails_q[rd_acct];
  assign rd_lock  = lock_q[rd_acct];

  always_comb begin
    bal_d   = bal_q;
    fails_d = fails_q;
    lock_d  = lock_q;
    if (wr_en) begin
      bal_d[wr_acct]   = wr_bal;
      fails_d[wr_acct] = wr_fails;
      lock_d[wr_acct]  = wr_lock;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i]   <= INIT_BALANCE;
        fails_q[i] <= '0;
      end
      lock_q <= '0;
    end else begin
      bal_q   <= bal_d;
      fails_q <= fails_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: rtl/atm_bank_host.sv
// Account-authority responder: one transaction at a time,
// IDLE -> EXEC -> RESP, with session and response registers.
module atm_bank_host
  import atm_pkg::*;
#(
  parameter int NUM_ACCTS = 4,
  localparam int ACCT_W = $clog2(NUM_ACCTS),
  parameter int AMT_W = 7,
  parameter int PIN_W = 2,
  parameter logic [AMT_W-1:0] INIT_BALANCE = AMT_W'(DEF_INIT_BALANCE),
  parameter logic [PIN_W-1:0] INIT_PIN = PIN_W'(DEF_INIT_PIN),
  parameter logic [AMT_W-1:0] THRESHOLD = AMT_W'(DEF_THRESHOLD),
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ACCT_W-1:0] req_acct,
  input  logic [PIN_W-1:0]  req_pin,
  input  logic [AMT_W-1:0]  req_amount,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_status,
  output logic [AMT_W-1:0]  rsp_balance,
  output logic              rsp_face_req
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  state_e state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ACCT_W-1:0] acct_q, acct_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic              sess_open_q, sess_open_d;
  logic [ACCT_W-1:0] sess_acct_q, sess_acct_d;
  logic [2:0]        status_q, status_d;
  logic [AMT_W-1:0]  bal_q, bal_d;
  logic              face_q, face_d;

  logic [AMT_W-1:0]  rd_bal, wr_bal;
  logic [FAIL_W-1:0] rd_fails, wr_fails, fails_inc;
  logic              rd_lock, wr_lock, wr_en;
  logic [AMT_W:0]    sum;
  logic              sess_hit;

  atm_acct_table #(
    .NUM_ACCTS(NUM_ACCTS),
    .ACCT_W(ACCT_W),
    .AMT_W(AMT_W),
    .FAIL_W(FAIL_W),
    .INIT_BALANCE(INIT_BALANCE)
  ) u_table (
    .clk(clk),
    .reset(reset),
    .rd_acct(acct_q),
    .rd_bal(rd_bal),
    .rd_fails(rd_fails),
    .rd_lock(rd_lock),
    .wr_en(wr_en),
    .wr_acct(acct_q),
    .wr_bal(wr_bal),
    .wr_fails(wr_fails),
    .wr_lock(wr_lock)
  );

  assign req_ready    = (state_q == S_IDLE) && reset;
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_status   = status_q;
  assign rsp_balance  = bal_q;
  assign rsp_face_req = face_q;

  assign sum       = {1'b0, rd_bal} + {1'b0, amt_q};
  assign fails_inc = rd_fails + 1'b1;
  assign sess_hit  = sess_open_q && (sess_acct_q == acct_q);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acct_d      = acct_q;
    pin_d       = pin_q;
    amt_d       = amt_q;
    sess_open_d = sess_open_q;
    sess_acct_d = sess_acct_q;
    status_d    = status_q;
    bal_d       = bal_q;
    face_d      = face_q;
    wr_en       = 1'b0;
    wr_bal      = rd_bal;
    wr_fails    = rd_fails;
    wr_lock     = rd_lock;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          acct_d  = req_acct;
          pin_d   = req_pin;
          amt_d   = req_amount;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d  = S_RESP;
        wr_en    = 1'b1;
        status_d = ST_OK;
        bal_d    = '0;
        face_d   = 1'b0;
        if (op_q == OP_VERIFY) begin
          if (rd_lock) begin
            status_d = ST_LOCKED;
          end else if (pin_q == INIT_PIN) begin
            wr_fails    = '0;
            sess_open_d = 1'b1;
            sess_acct_d = acct_q;
            bal_d       = rd_bal;
          end else begin
            wr_fails    = fails_inc;
            sess_open_d = 1'b0;
            if (fails_inc == FAIL_W'(MAX_TRIES)) begin
              wr_lock  = 1'b1;
              status_d = ST_LOCKED;
            end else begin
              status_d = ST_BAD_PIN;
            end
          end
        end else if (op_q > OP_CLOSE) begin
          status_d = ST_ILLEGAL;
        end else if (!sess_hit) begin
          status_d = ST_NO_SESS;
        end else begin
          case (op_q)
            OP_WITHDRAW: begin
              if (amt_q > rd_bal) begin
                status_d = ST_INSUFF;
              end else begin
                wr_bal = rd_bal - amt_q;
                bal_d  = rd_bal - amt_q;
                face_d = (amt_q > THRESHOLD);
              end
            end
            OP_DEPOSIT: begin
              if (sum[AMT_W]) begin
                status_d = ST_OVERFLOW;
              end else begin
                wr_bal = sum[AMT_W-1:0];
                bal_d  = sum[AMT_W-1:0];
              end
            end
            OP_CLOSE: begin
              sess_open_d = 1'b0;
              bal_d       = rd_bal;
            end
            default: bal_d = rd_bal;
          endcase
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      acct_q      <= '0;
      pin_q       <= '0;
      amt_q       <= '0;
      sess_open_q <= 1'b0;
      sess_acct_q <= '0;
      status_q    <= '0;
      bal_q       <= '0;
      face_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acct_q      <= acct_d;
      pin_q       <= pin_d;
      amt_q       <= amt_d;
      sess_open_q <= sess_open_d;
      sess_acct_q <= sess_acct_d;
      status_q    <= status_d;
      bal_q       <= bal_d;
      face_q      <= face_d;
    end
  end

endmodule

// File: tb/tb_atm_bank_host.sv
// Randomized and directed bench for atm_bank_host against
// a transaction-level account model.
module tb_atm_bank_host;

  logic       clk = 0;
  logic       reset = 0;
  logic       req_valid = 0;
  logic       req_ready;
  logic [2:0] req_op = 0;
  logic [1:0] req_acct = 0;
  logic [1:0] req_pin = 0;
  logic [6:0] req_amount = 0;
  logic       rsp_valid;
  logic       rsp_ready = 0;
  logic [2:0] rsp_status;
  logic [6:0] rsp_balance;
  logic       rsp_face_req;

  atm_bank_host dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_acct(req_acct),
    .req_pin(req_pin),
    .req_amount(req_amount),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_status(rsp_status),
    .rsp_balance(rsp_balance),
    .rsp_face_req(rsp_face_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_bal [4];
  int m_fails [4];
  int m_lock [4];
  int m_so, m_sa;
  int exp_st = 0, exp_bal = 0, exp_face = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bal[i] = 110;
      m_fails[i] = 0;
      m_lock[i] = 0;
    end
    m_so = 0;
    m_sa = 0;
  endtask

  task automatic model_exec(input int op, input int a, input int p, input int amt);
    exp_st = 0;
    exp_bal = 0;
    exp_face = 0;
    if (op == 0) begin
      if (m_lock[a] != 0) exp_st = 2;
      else if (p == 2) begin
        m_fails[a] = 0;
        m_so = 1;
        m_sa = a;
        exp_bal = m_bal[a];
      end else begin
        m_fails[a]++;
        m_so = 0;
        if (m_fails[a] == 3) begin
          m_lock[a] = 1;
          exp_st = 2;
        end else exp_st = 1;
      end
    end else if (op > 4) exp_st = 6;
    else if (!(m_so == 1 && m_sa == a)) exp_st = 5;
    else if (op == 1) begin
      if (amt > m_bal[a]) exp_st = 3;
      else begin
        m_bal[a] -= amt;
        exp_bal = m_bal[a];
        exp_face = (amt > 90) ? 1 : 0;
      end
    end else if (op == 2) begin
      if (m_bal[a] + amt > 127) exp_st = 4;
      else begin
        m_bal[a] += amt;
        exp_bal = m_bal[a];
      end
    end else begin
      exp_bal = m_bal[a];
      if (op == 4) m_so = 0;
    end
  endtask

  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      check("rsp_status", rsp_status, exp_st);
      check("rsp_balance", rsp_balance, exp_bal);
      check("rsp_face", rsp_face_req, exp_face);
      check("req_ready_busy", req_ready, 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_balance", rsp_balance, 0);
    check("rst_rsp_face", rsp_face_req, 0);
    reset = 1;
    #1 check("rel_req_ready", req_ready, 1);
    model_reset();
  endtask

  task automatic send(input int op, input int a, input int p, input int amt);
    int n;
    @(negedge clk);
    req_valid = 1;
    req_op = 3'(op);
    req_acct = 2'(a);
    req_pin = 2'(p);
    req_amount = 7'(amt);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("req_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = $urandom_range(0, 1) == 1;
    req_op = 3'($urandom);
    req_acct = 2'($urandom);
    req_pin = 2'($urandom);
    req_amount = 7'($urandom);
  endtask

  task automatic txn(input int op, input int a, input int p, input int amt,
                     input int hold, output int st, output int bal, output int face);
    model_exec(op, a, p, amt);
    send(op, a, p, amt);
    @(negedge clk);
    check("lat_exec_valid", rsp_valid, 0);
    check("lat_exec_ready", req_ready, 0);
    @(negedge clk);
    check("lat_resp_valid", rsp_valid, 1);
    st = rsp_status;
    bal = rsp_balance;
    face = rsp_face_req;
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
    req_valid = 0;
  endtask

  int st, bal, face;

  initial begin
    model_reset();
    do_reset();

    txn(0, 1, 2, 0, 0, st, bal, face);
    check("v1_st", st, 0);
    check("v1_bal", bal, 110);
    txn(1, 1, 0, 30, 1, st, bal, face);
    check("w30_st", st, 0);
    check("w30_bal", bal, 80);
    check("w30_face", face, 0);
    txn(4, 1, 0, 0, 0, st, bal, face);
    check("close_st", st, 0);
    check("close_bal", bal, 80);

    txn(0, 2, 1, 0, 0, st, bal, face);
    check("bad1", st, 1);
    txn(0, 2, 1, 0, 0, st, bal, face);
    check("bad2", st, 1);
    txn(0, 2, 1, 0, 0, st, bal, face);
    check("bad3_lock", st, 2);
    txn(0, 2, 2, 0, 0, st, bal, face);
    check("locked_good_pin", st, 2);
    check("locked_bal", bal, 0);
    do_reset();
    txn(0, 2, 2, 0, 0, st, bal, face);
    check("unlock_st", st, 0);

    txn(0, 0, 2, 0, 0, st, bal, face);
    txn(1, 0, 0, 111, 0, st, bal, face);
    check("insuff_st", st, 3);
    txn(1, 0, 0, 91, 0, st, bal, face);
    check("w91_bal", bal, 19);
    check("w91_face", face, 1);
    txn(1, 0, 0, 19, 0, st, bal, face);
    check("w19_st", st, 0);
    check("w19_bal", bal, 0);

    txn(0, 3, 2, 0, 0, st, bal, face);
    txn(2, 3, 0, 17, 0, st, bal, face);
    check("d17_bal", bal, 127);
    txn(2, 3, 0, 1, 0, st, bal, face);
    check("d1_ovf", st, 4);
    txn(3, 3, 0, 0, 0, st, bal, face);
    check("bal127", bal, 127);

    txn(3, 0, 0, 0, 0, st, bal, face);
    check("nosess_bal", st, 5);
    txn(0, 1, 2, 0, 0, st, bal, face);
    txn(1, 2, 0, 5, 0, st, bal, face);
    check("nosess_wrong_acct", st, 5);
    txn(0, 2, 2, 0, 0, st, bal, face);
    check("acct2_unchanged", bal, 110);
    txn(7, 2, 2, 0, 0, st, bal, face);
    check("illegal", st, 6);

    txn(3, 2, 0, 0, 5, st, bal, face);

    txn(0, 1, 2, 0, 0, st, bal, face);
    send(1, 1, 0, 50);
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
    req_valid = 0;
    model_reset();
    @(negedge clk);
    check("rst_exec_drop", rsp_valid, 0);
    txn(0, 1, 2, 0, 0, st, bal, face);
    check("rst_exec_bal", bal, 110);

    for (int i = 0; i < 300; i++) begin
      int op, a, p, amt, r;
      if (i % 60 == 59) do_reset();
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: op = 0;
        3, 4: op = 1;
        5: op = 2;
        6: op = 3;
        7: op = 4;
        8: op = $urandom_range(5, 7);
        default: op = 0;
      endcase
      a = $urandom_range(0, 3);
      if (m_so == 1 && $urandom_range(0, 9) < 8) a = m_sa;
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2;
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 40);
      txn(op, a, p, amt, $urandom_range(0, 3), st, bal, face);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1);
  end

endmodule

// File: doc/atm_bank_host.md
# atm_bank_host

Account-authority responder on the far side of the ATM controller's host link. It accepts one transaction at a time: PIN verify, withdraw, deposit, balance inquiry or session close. For each transaction it checks PIN, lockout and funds, updates a small on-chip account table, and returns a status, the resulting balance and a face-recognition flag. The ATM front-end FSM initiates; this block only responds.

## Interface
Parameters:
- NUM_ACCTS, 4: accounts held; must be a power of two. ACCT_W = clog2(NUM_ACCTS).
- AMT_W, 7: amount/balance width.
- PIN_W, 2: PIN width.
- INIT_BALANCE, 7'd110: per-account balance after reset.
- INIT_PIN, 2'b10: per-account PIN after reset.
- THRESHOLD, 7'd90: withdraw amount above which face recognition is flagged.
- MAX_TRIES, 3: consecutive bad PINs that lock an account.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  000 VERIFY, 001 WITHDRAW, 010 DEPOSIT, 011 BALANCE, 100 CLOSE; others are illegal.
- req_acct  in  ACCT_W  account index.
- req_pin  in  PIN_W  PIN; used by VERIFY only.
- req_amount  in  AMT_W  amount; used by WITHDRAW and DEPOSIT.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  ATM consumes the response.
- rsp_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 OVERFLOW, 5 NO_SESSION, 6 ILLEGAL_OP.
- rsp_balance  out  AMT_W  account balance after the operation when status is OK; 0 otherwise.
- rsp_face_req  out  1  OK withdraw with amount > THRESHOLD.

## Operation
FSM states:
- IDLE: req_ready=1. Capture op, acct, pin and amount when req_valid&&req_ready → EXEC.
- EXEC: evaluate the request, write the account table, register the response → RESP.
- RESP: rsp_valid=1. On rsp_ready → IDLE.

Session state: session_open (1 bit) plus session_acct. WITHDRAW, DEPOSIT, BALANCE and CLOSE require session_open && session_acct==req_acct. Otherwise the response is NO_SESSION and nothing is modified.

Per-op behaviour:
- VERIFY:
  - Account locked → LOCKED; fail count unchanged.
  - PIN match → OK; fail count cleared; session opened on req_acct, replacing any prior session.
  - PIN mismatch → fail count +1 and session closed. If the new count equals MAX_TRIES, lock is set and status is LOCKED; otherwise BAD_PIN.
- WITHDRAW:
  - amount > balance → INSUFFICIENT.
  - Otherwise balance -= amount and status OK. amount==balance is allowed and gives balance 0.
  - rsp_face_req=1 iff OK and amount > THRESHOLD (91 flags; 90 does not).
- DEPOSIT: the sum is computed at AMT_W+1 bits. If the sum exceeds 2^AMT_W−1 → OVERFLOW, balance unchanged; otherwise OK and balance updated.
- BALANCE: OK; returns the balance.
- CLOSE: OK; returns the balance; session closed.
- Illegal op → ILLEGAL_OP; no state change.
- Amount 0 is legal for WITHDRAW and DEPOSIT: OK, balance unchanged.

Reset and locking:
- Reset restores every account to INIT_BALANCE and INIT_PIN, clears fail counts, locks and the session, and returns the FSM to IDLE.
- Reset is the only way to clear a lock.

## Timing
- Reset values: req_ready=0 while reset is low and 1 in the first cycle after release. rsp_valid=0, rsp_status=0, rsp_balance=0, rsp_face_req=0.
- Latency: request accepted at edge N; table updated at edge N+1; rsp_valid high from edge N+1 through the edge where rsp_ready is sampled high.
- Throughput: at most one transaction per 3 cycles. req_ready=0 throughout EXEC and RESP.
- While rsp_valid && !rsp_ready, all rsp_* outputs hold stable.
- Reset asserted during EXEC takes priority: no table write for that transaction.
- Reset asserted during RESP drops the pending response.
- req_* inputs are ignored outside IDLE.

## Structure
- Shared package atm_pkg holds:
  - op and status encodings;
  - FSM state encoding;
  - defaults 90 / 110 / 2'b10 / 3, also used by the ATM front-end.
- Sub-module atm_acct_table holds per-account balance, fail count and lock bit. It has one combinational read port, one synchronous write port, and reset to the parameterised initial values.
- The top level holds the FSM, the session registers and the response registers.

## Test plan
- VERIFY acct 1 with pin 2'b10 → OK, balance 110. Then WITHDRAW 30 → OK, balance 80, face 0. Then CLOSE → OK, balance 80.
- VERIFY acct 2 with pin 2'b01 three times → BAD_PIN, BAD_PIN, LOCKED. Then VERIFY with pin 2'b10 → LOCKED. Reset, then VERIFY with 2'b10 → OK.
- With a session open on acct 0:
  - WITHDRAW 111 → INSUFFICIENT, balance unchanged;
  - WITHDRAW 91 → OK, balance 19, face 1;
  - WITHDRAW 19 → OK, balance 0.
- With a session open on acct 3: DEPOSIT 17 → OK, balance 127. Then DEPOSIT 1 → OVERFLOW; a following BALANCE → 127.
- With no session, BALANCE on acct 0 → NO_SESSION. With a session open on acct 1, WITHDRAW on acct 2 → NO_SESSION; acct 2 balance stays 110.
- Hold rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0 throughout. Separately, assert reset during EXEC of a WITHDRAW 50 → after reset, a VERIFY on that account returns balance 110.
